// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of the two-port
// memory arbiter. The "slave" modport is the arbiter's view and the
// "master" modport is the view of the surrounding core/memory model.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 64
);
    // I-side (instruction fetch, read-only)
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;
    logic          i_ack;
    // D-side (load/store)
    logic          d_req;
    logic [1:0]    d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    // Shared memory port
    logic          m_req;
    logic [1:0]    m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    // Status
    logic          busy;
    logic          owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
               busy, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
               busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between instruction fetch
// (I-side) and load/store (D-side), one transaction at a time, D first.
// Optional macro ARB_STARVE_GUARD_EN adds an I-side anti-starvation guard
// (I wins once D has taken MAX_D_STREAK grants while I was waiting).
//
// Handshakes: a requester raises req with stable addr/we/wdata and holds it
// until its one-cycle ack; req must be low in the cycle after ack, otherwise
// it is taken as a new request. On the memory side m_req stays high with
// stable m_addr/m_we/m_wdata until the edge where m_ready=1 completes it;
// m_ready is ignored while m_req is low. All outputs come from flops.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 64
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int MAX_D_STREAK = 4
`endif
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   state_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    we_q, we_d;
    logic          owner_q, owner_d;
    logic          m_req_q, m_req_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          busy_q, busy_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          guard_fire;
    logic          d_wins;
    logic          i_wins;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0]    streak_q, streak_d;

    // I is forced through once D has won MAX_D_STREAK grants over it
    assign guard_fire = bus.i_req && bus.d_req && (streak_q == 3'(MAX_D_STREAK));

    // Count D grants made while I waits (saturating); any I grant clears it
    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (d_wins && bus.i_req) begin
                if (streak_q != 3'd7) begin
                    streak_d = streak_q + 3'd1;
                end
            end else if (i_wins) begin
                streak_d = 3'd0;
            end
        end
    end

    // Streak register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= 3'd0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign guard_fire = 1'b0;
`endif

    assign d_wins = bus.d_req && !guard_fire;
    assign i_wins = bus.i_req && !d_wins;

    // Next-state: grant in IDLE, wait for m_ready in ISSUE, ack in DONE
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        owner_d   = owner_q;
        m_req_d   = 1'b0;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    // 2'b11 is an alias of a full 64-bit write
                    we_d    = (bus.d_we == 2'b11) ? 2'b10 : bus.d_we;
                    owner_d = 1'b1;
                    m_req_d = 1'b1;
                    state_d = ISSUE;
                end else if (i_wins) begin
                    addr_d  = bus.i_addr;
                    wdata_d = '0;
                    we_d    = 2'b00;
                    owner_d = 1'b0;
                    m_req_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_ready) begin
                    state_d = DONE;
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                        if (we_q == 2'b00) begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        // addr[2] selects which 32-bit word of the line is fetched
                        i_rdata_d = addr_q[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
                    end
                end else begin
                    m_req_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 2'b00;
            owner_q   <= 1'b0;
            m_req_q   <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            owner_q   <= owner_d;
            m_req_q   <= m_req_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            busy_q    <= busy_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
    assign state_o     = state_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified memory port of the 64-bit MIPS core between instruction fetch (I-side, read-only) and load/store (D-side, read/write). It sits between the core's fetch/memory stages and the memory/cache model. Each requester uses a req/ack handshake, and the block runs exactly one memory transaction at a time. D-side has priority, with an optional anti-starvation guard for I-side.

## Interface
- AW, 8, byte-address width of all address ports
- DW, 64, memory data width
- MAX_D_STREAK, 4, consecutive D grants allowed while I is pending (guard only)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  I-side request, held until i_ack
- i_addr  in  AW  I-side fetch address
- i_rdata  out  32  fetched instruction word
- i_ack  out  1  one-cycle completion pulse, I-side
- d_req  in  1  D-side request, held until d_ack
- d_we  in  2  00 read, 01 write low 32 bits, 10 write 64 bits, 11 treated as 10
- d_addr  in  AW  D-side address
- d_wdata  in  DW  D-side write data
- d_rdata  out  DW  D-side read data
- d_ack  out  1  one-cycle completion pulse, D-side
- m_req  out  1  memory request
- m_we  out  2  memory write code, same encoding as d_we
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data
- m_ready  in  1  memory completion, valid only while m_req=1
- busy  out  1  state is not IDLE
- owner  out  1  current/last grantee: 0 = I, 1 = D

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any req=1, pick a winner.
  - Latch the winner's addr, wdata and we into internal registers. An I grant forces we=00.
  - Set owner, then go to ISSUE.
- Arbitration: d_req wins over i_req when both are set, unless the guard fires (see Configuration).
- ISSUE:
  - m_req=1, with m_addr/m_we/m_wdata driven from the latched registers. These stay stable for the whole state.
  - On the edge where m_ready=1, capture read data and go to DONE.
- Read data capture:
  - D-side: d_rdata is loaded with m_rdata.
  - I-side: i_rdata is loaded with m_rdata[31:0] when the latched addr[2]=0, and m_rdata[63:32] when addr[2]=1.
  - On writes, d_rdata keeps its previous value.
- DONE: the owner's ack=1 for one cycle; next state is IDLE.
- Requester rule: req must be low in the cycle after its ack. An IDLE that sees a req still high treats it as a new request.
- Streak counter: 3-bit, saturating.
  - Increments on each D grant made while i_req=1.
  - Clears on any I grant.
- m_ready is ignored outside ISSUE.
- Changes to requester inputs after the grant have no effect on the transaction in flight.

## Timing
- Reset values (asynchronous, while reset=0):
  - state IDLE; m_req, i_ack, d_ack, busy all 0.
  - m_we=00, m_addr=0, m_wdata=0.
  - i_rdata=0, d_rdata=0, owner=0, streak=0.
- Reset asserted mid-transaction: m_req and ack drop immediately and the transaction is abandoned. After reset is released, the block starts in IDLE.
- Latency, with req first sampled at edge 0:
  - m_req is high in cycle 1.
  - If m_ready=1 in cycle 1, ack is high in cycle 2 and the block is back in IDLE in cycle 3.
  - Each wait cycle of m_ready adds one cycle.
- Minimum issue rate is one transaction per 3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ARB_STARVE_GUARD_EN defined: when i_req=1, d_req=1 and streak==MAX_D_STREAK, I wins the next grant and streak clears.
- ARB_STARVE_GUARD_EN undefined: strict D priority. The streak counter is not built; I can starve indefinitely.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs at reset values; after release, busy stays 0 while no req.
- Lone I fetch: i_addr=8, m_rdata=64'h1111_2222_3333_4444, m_ready=1 in cycle 1 -> i_rdata=32'h3333_4444 and i_ack pulses in cycle 2. Repeat with i_addr=12 -> 32'h1111_2222.
- Collision: i_req and d_req high on the same edge, with d_we=10, d_addr=100, d_wdata=7 -> the first m_req carries m_we=10, m_addr=100, m_wdata=7 and d_ack is first; the I fetch follows, with i_ack 3 cycles after d_ack.
- Memory wait: hold m_ready=0 for 3 cycles of a D read -> m_req/m_addr stay stable for 4 cycles; d_ack comes one cycle after m_ready, with d_rdata=m_rdata.
- Starvation: d_req re-asserted after every ack, i_req held high, MAX_D_STREAK=4 -> with the macro, the 5th grant goes to I; without it, no i_ack within 20 grants.
- Reset mid-ISSUE: drive reset=0 during a wait -> m_req falls without waiting for an edge; after release, a new i_req completes normally.
